// File: rtl/l1_snoop_engine_pkg.sv
// rtl/l1_snoop_engine_pkg.sv - shared cache types, address widths and coherence states
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef L1_INDEX_BITS
`define L1_INDEX_BITS 6
`endif

package l1_snoop_engine_pkg;

  localparam int CACHELINE_BITS = `CACHELINE_BITS;
  localparam int ADDR_BITS      = `ADDR_BITS;
  localparam int OFFSET_BITS    = `OFFSET_BITS;
  localparam int L1_INDEX_BITS  = `L1_INDEX_BITS;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int TAG_BITS       = LINE_ADDR_BITS - L1_INDEX_BITS;

  typedef enum logic [2:0] {
    COH_I = 3'd0,
    COH_S = 3'd1,
    COH_E = 3'd2,
    COH_O = 3'd3,
    COH_M = 3'd4
  } coh_state_t;

  typedef enum logic [2:0] {
    BUS_RD   = 3'd0,
    BUS_RDX  = 3'd1,
    BUS_UPGR = 3'd2,
    BUS_WB   = 3'd3
  } bus_req_t;

  typedef struct packed {
    coh_state_t                state;
    logic [TAG_BITS-1:0]       tag;
    logic [CACHELINE_BITS-1:0] cacheline;
  } l1_cacheline_t;

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [LINE_ADDR_BITS-1:0] line_addr);
    return line_addr[LINE_ADDR_BITS-1:L1_INDEX_BITS];
  endfunction

endpackage

// File: rtl/l1_snoop_engine_fifo.sv
// rtl/l1_snoop_engine_fifo.sv - snoop_fifo: power-of-two request queue with registered head storage
module snoop_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/l1_snoop_engine.sv
// rtl/l1_snoop_engine.sv - L1 snoop engine: queued bus snoops, state update, beat-wise line supply (MOESI with SNOOP_OWNED_EN)
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module l1_snoop_engine
  import l1_snoop_engine_pkg::*;
#(
  parameter int LINE_BITS  = `CACHELINE_BITS,
  parameter int BEAT_BITS  = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      snp_valid,
  output logic                      snp_ready,
  input  logic [LINE_ADDR_BITS-1:0] snp_addr,
  input  bus_req_t                  snp_req,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BEAT_BITS-1:0]      rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_shared,
  output logic [LINE_ADDR_BITS-1:0] cache_addr,
  input  l1_cacheline_t             cacheline_lookup,
  output l1_cacheline_t             cacheline_update,
  output logic                      update_valid
);

  localparam int NBEATS = LINE_BITS / BEAT_BITS;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

`ifdef SNOOP_OWNED_EN
  localparam coh_state_t RD_FROM_M = COH_O;
`else
  localparam coh_state_t RD_FROM_M = COH_S;
`endif

  typedef struct packed {
    logic [LINE_ADDR_BITS-1:0] addr;
    bus_req_t                  req;
  } snoop_entry_t;

  typedef enum logic {
    LOOKUP  = 1'b0,
    RESPOND = 1'b1
  } fsm_state_t;

  fsm_state_t            state;
  logic [BEAT_W-1:0]     beat;
  logic [LINE_BITS-1:0]  line_buf;
  snoop_entry_t          push_entry;
  snoop_entry_t          head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  evaluate;
  logic                  hit;
  logic                  supply;
  coh_state_t            next_coh;

  assign snp_ready  = reset_n && !fifo_full;
  assign push       = snp_valid && snp_ready;
  assign push_entry = '{addr: snp_addr, req: snp_req};
  assign evaluate   = (state == LOOKUP) && !fifo_empty;
  assign cache_addr = head_entry.addr;

  snoop_fifo #(
    .WIDTH ($bits(snoop_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (evaluate),
    .data    (push_entry),
    .head    (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign hit = (cacheline_lookup.state != COH_I) &&
               (cacheline_lookup.tag == tag_of(head_entry.addr));

  always_comb begin
    update_valid = 1'b0;
    supply       = 1'b0;
    next_coh     = cacheline_lookup.state;
    if (evaluate && hit) begin
      case (head_entry.req)
        BUS_UPGR: begin
          update_valid = 1'b1;
          next_coh     = COH_I;
        end
        BUS_RD: begin
          update_valid = 1'b1;
          supply       = 1'b1;
          if (cacheline_lookup.state == COH_E)      next_coh = COH_S;
          else if (cacheline_lookup.state == COH_M) next_coh = RD_FROM_M;
        end
        BUS_RDX: begin
          update_valid = 1'b1;
          supply       = (cacheline_lookup.state != COH_S);
          next_coh     = COH_I;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cacheline_update       = cacheline_lookup;
    cacheline_update.state = next_coh;
  end

  assign rsp_valid  = (state == RESPOND);
  assign rsp_shared = (state == RESPOND);
  assign rsp_last   = (state == RESPOND) && (beat == BEAT_W'(NBEATS-1));
  assign rsp_data   = (state == RESPOND) ? line_buf[int'(beat)*BEAT_BITS +: BEAT_BITS] : '0;

  // The FIFO never pops in RESPOND, so the head stays parked until the line is fully sent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOOKUP;
      beat     <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          if (supply) begin
            line_buf <= LINE_BITS'(cacheline_lookup.cacheline);
            beat     <= '0;
            state    <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            if (rsp_last) state <= LOOKUP;
            else          beat  <= beat + 1'b1;
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_snoop_engine.sv
// tb/tb_l1_snoop_engine.sv - directed bench for l1_snoop_engine with a queue-based coherence model
`timescale 1ns/1ps
module tb_l1_snoop_engine;
  import l1_snoop_engine_pkg::*;

  localparam int LB   = 512;
  localparam int BB   = 128;
  localparam int NB   = LB / BB;
  localparam int IDXN = 1 << L1_INDEX_BITS;

`ifdef SNOOP_OWNED_EN
  localparam coh_state_t M_ON_RD = COH_O;
`else
  localparam coh_state_t M_ON_RD = COH_S;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      snp_valid = 1'b0;
  logic                      snp_ready;
  logic [LINE_ADDR_BITS-1:0] snp_addr = '0;
  bus_req_t                  snp_req = BUS_RD;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [BB-1:0]             rsp_data;
  logic                      rsp_last;
  logic                      rsp_shared;
  logic [LINE_ADDR_BITS-1:0] cache_addr;
  l1_cacheline_t             cacheline_lookup;
  l1_cacheline_t             cacheline_update;
  logic                      update_valid;

  always #5 clk = ~clk;

  l1_snoop_engine #(.LINE_BITS(LB), .BEAT_BITS(BB), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .snp_valid        (snp_valid),
    .snp_ready        (snp_ready),
    .snp_addr         (snp_addr),
    .snp_req          (snp_req),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .rsp_shared       (rsp_shared),
    .cache_addr       (cache_addr),
    .cacheline_lookup (cacheline_lookup),
    .cacheline_update (cacheline_update),
    .update_valid     (update_valid)
  );

  // Cache environment and an independent model of the same lines.
  l1_cacheline_t cache_mem [IDXN];
  l1_cacheline_t mdl [IDXN];
  assign cacheline_lookup = cache_mem[int'(cache_addr[L1_INDEX_BITS-1:0])];

  typedef struct { int idx; l1_cacheline_t val; } upd_t;
  typedef struct { logic [BB-1:0] data; logic last; } beat_t;
  upd_t  exp_upd [$];
  beat_t exp_beat [$];
  logic [BB-1:0] seen_data [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int upd_seen = 0;
  int beats_seen = 0;
  int push_cyc = 0;
  int first_rsp_cyc = 0;
  coh_state_t last_upd_state = COH_I;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_ADDR_BITS-1:0] mk(input logic [TAG_BITS-1:0] t, input int i);
    return {t, L1_INDEX_BITS'(i)};
  endfunction

  function automatic logic [LB-1:0] pat4(input logic [BB-1:0] b0, input logic [BB-1:0] b1,
                                         input logic [BB-1:0] b2, input logic [BB-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic set_line(input int i, input coh_state_t s, input logic [TAG_BITS-1:0] t,
                          input logic [LB-1:0] d);
    l1_cacheline_t v;
    v.state = s;
    v.tag = t;
    v.cacheline = d;
    cache_mem[i] <= v;
    mdl[i] = v;
  endtask

  // Coherence rules applied in request order at enqueue time.
  task automatic model_push(input logic [LINE_ADDR_BITS-1:0] a, input bus_req_t r);
    int idx;
    l1_cacheline_t ln;
    coh_state_t ns;
    bit upd;
    bit sup;
    idx = int'(a[L1_INDEX_BITS-1:0]);
    ln = mdl[idx];
    ns = ln.state;
    upd = 0;
    sup = 0;
    if (ln.state == COH_I || ln.tag != a[LINE_ADDR_BITS-1:L1_INDEX_BITS]) return;
    case (r)
      BUS_UPGR: begin upd = 1; ns = COH_I; end
      BUS_RD: begin
        upd = 1;
        sup = 1;
        ns = (ln.state == COH_E) ? COH_S : (ln.state == COH_M) ? M_ON_RD : ln.state;
      end
      BUS_RDX: begin upd = 1; sup = (ln.state != COH_S); ns = COH_I; end
      default: ;
    endcase
    if (sup)
      for (int b = 0; b < NB; b++) exp_beat.push_back('{ln.cacheline[b*BB +: BB], b == NB-1});
    if (upd) begin
      ln.state = ns;
      mdl[idx] = ln;
      exp_upd.push_back('{idx, ln});
    end
  endtask

  task automatic env_loop();
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (reset_n && update_valid)
        cache_mem[int'(cache_addr[L1_INDEX_BITS-1:0])] <= cacheline_update;
    end
  endtask

  task automatic monitor_loop();
    bit stalled;
    bit prev_valid;
    logic [BB-1:0] held;
    upd_t u;
    beat_t bt;
    stalled = 0;
    prev_valid = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 0;
        prev_valid = 0;
        continue;
      end
      if (snp_valid && snp_ready) begin
        model_push(snp_addr, snp_req);
        push_cyc = cyc;
      end
      if (update_valid) begin
        check("update_expected", exp_upd.size() != 0, 1);
        if (exp_upd.size() != 0) begin
          u = exp_upd.pop_front();
          check("upd_index", cache_addr[L1_INDEX_BITS-1:0], u.idx);
          check("upd_line", cacheline_update, u.val);
          upd_seen++;
          last_upd_state = cacheline_update.state;
        end
      end
      if (rsp_valid) begin
        if (!prev_valid) first_rsp_cyc = cyc;
        check("rsp_shared", rsp_shared, 1);
        if (stalled) check("stall_hold", rsp_data, held);
        if (rsp_ready) begin
          check("beat_expected", exp_beat.size() != 0, 1);
          if (exp_beat.size() != 0) begin
            bt = exp_beat.pop_front();
            check("beat_data", rsp_data, bt.data);
            check("beat_last", rsp_last, bt.last);
          end
          seen_data.push_back(rsp_data);
          beats_seen++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = rsp_data;
        end
      end else begin
        check("idle_rsp_zero", {rsp_data, rsp_last, rsp_shared}, 0);
        check("valid_held_under_stall", stalled, 0);
        stalled = 0;
      end
      prev_valid = rsp_valid;
    end
  endtask

  task automatic push(input logic [LINE_ADDR_BITS-1:0] a, input bus_req_t r);
    bit ok;
    ok = 0;
    snp_valid = 1'b1;
    snp_addr = a;
    snp_req = r;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (snp_ready) ok = 1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    snp_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_upd.size() == 0 && exp_beat.size() == 0 && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", ok, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    check("rsp_started", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int seq [6];
    bit ok;
    seq = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < IDXN; i++) set_line(i, COH_I, '0, '0);
    fork
      env_loop();
      monitor_loop();
    join_none

    // Reset behaviour
    #2;
    check("reset_snp_ready", snp_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_update_valid", update_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("ready_after_reset", snp_ready, 1);
    @(posedge clk);
    #1;

    // BUS_RD hit on E, all-0xAA line
    set_line(1, COH_E, 20'h12345, {64{8'hAA}});
    rsp_ready = 1'b1;
    beats_seen = 0; upd_seen = 0; seen_data.delete();
    push(mk(20'h12345, 1), BUS_RD);
    wait_idle();
    check("rd_e_state", last_upd_state, COH_S);
    check("rd_e_beats", beats_seen, 4);
    check("rd_e_latency", first_rsp_cyc - push_cyc, 2);
    check("rd_e_beat3", seen_data[3], {16{8'hAA}});

    // BUS_RDX on S (no supply) then on M (supply)
    set_line(2, COH_S, 20'h00B0B, {64{8'h5C}});
    set_line(3, COH_M, 20'h00C0C, pat4({4{32'h30}}, {4{32'h31}}, {4{32'h32}}, {4{32'h33}}));
    beats_seen = 0; upd_seen = 0; seen_data.delete();
    push(mk(20'h00B0B, 2), BUS_RDX);
    push(mk(20'h00C0C, 3), BUS_RDX);
    wait_idle();
    check("rdx_updates", upd_seen, 2);
    check("rdx_beats", beats_seen, 4);
    check("rdx_state", last_upd_state, COH_I);
    check("rdx_m_beat0", seen_data[0], {4{32'h30}});

    // Queue fills while the bus stalls a response
    set_line(4, COH_E, 20'h00004, {64{8'h44}});
    set_line(5, COH_S, 20'h00005, {64{8'h55}});
    set_line(7, COH_M, 20'h00007, {64{8'h77}});
    rsp_ready = 1'b0;
    beats_seen = 0; upd_seen = 0;
    push(mk(20'h00004, 4), BUS_RD);
    wait_rsp_valid();
    push(mk(20'h00999, 5), BUS_RD);
    push(mk(20'h00001, 6), BUS_RD);
    push(mk(20'h00998, 5), BUS_RDX);
    push(mk(20'h00997, 5), BUS_UPGR);
    check("full_not_ready", snp_ready, 0);
    rel_cyc = 0;
    fork
      push(mk(20'h00007, 7), BUS_UPGR);
      begin
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        rel_cyc = cyc;
      end
    join
    check("fifth_accept_cycle", push_cyc - rel_cyc, 5);
    wait_idle();
    check("full_updates", upd_seen, 2);
    check("full_beats", beats_seen, 4);
    check("upgr_state", last_upd_state, COH_I);

    // BUS_RD on M: O with the owned state, S otherwise
    set_line(8, COH_M, 20'h00008, {64{8'h88}});
    push(mk(20'h00008, 8), BUS_RD);
    wait_idle();
    check("rd_m_state", last_upd_state, M_ON_RD);

    // Stalls mid-response
    set_line(9, COH_O, 20'h00009, pat4({4{32'hB0}}, {4{32'hB1}}, {4{32'hB2}}, {4{32'hB3}}));
    rsp_ready = 1'b0;
    beats_seen = 0; seen_data.delete();
    push(mk(20'h00009, 9), BUS_RD);
    wait_rsp_valid();
    for (int i = 0; i < 6; i++) begin
      rsp_ready = seq[i][0];
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_idle();
    check("stall_beats", beats_seen, 4);
    check("stall_beat1", seen_data[1], {4{32'hB1}});
    check("stall_beat3", seen_data[3], {4{32'hB3}});
    check("rd_o_state", last_upd_state, COH_O);

    // WB hit and RD on an invalid line: nothing happens
    set_line(10, COH_M, 20'h0000A, {64{8'hA5}});
    upd_seen = 0; beats_seen = 0;
    push(mk(20'h0000A, 10), BUS_WB);
    push(mk(20'h00001, 6), BUS_RD);
    repeat (6) @(posedge clk);
    #1;
    check("noop_updates", upd_seen, 0);
    check("noop_beats", beats_seen, 0);

    // Reset during beat 2 discards the response and the queue
    set_line(11, COH_E, 20'h0000B, pat4({4{32'hC0}}, {4{32'hC1}}, {4{32'hC2}}, {4{32'hC3}}));
    set_line(12, COH_M, 20'h0000C, {64{8'hCC}});
    beats_seen = 0;
    push(mk(20'h0000B, 11), BUS_RD);
    push(mk(20'h0000C, 12), BUS_RDX);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (beats_seen == 2) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    check("reached_beat2", ok, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_update_valid", update_valid, 0);
    check("abort_snp_ready", snp_ready, 0);
    exp_upd.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("rerelease_snp_ready", snp_ready, 1);
    upd_seen = 0; beats_seen = 0;
    repeat (8) @(posedge clk);
    #1;
    check("discard_updates", upd_seen, 0);
    check("discard_beats", beats_seen, 0);

    check("final_upd_queue", exp_upd.size(), 0);
    check("final_beat_queue", exp_beat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_snoop_engine.md
L1_SNOOP_ENGINE -- requirements
Module: l1_snoop_engine

Interface
REQ-001 SHALL have parameter LINE_BITS, default `CACHELINE_BITS: cacheline width.
REQ-002 SHALL have parameter BEAT_BITS, default 128: response beat width; LINE_BITS is an integer multiple of it; NBEATS = LINE_BITS/BEAT_BITS.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: snoop request queue depth; a power of two, at least 2.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- snp_valid  in  1  snoop request valid.
- snp_ready  out  1  engine can accept a request.
- snp_addr  in  ADDR_BITS-OFFSET_BITS  line address of the request.
- snp_req  in  bus_req_t  request type: BUS_RD, BUS_RDX, BUS_UPGR or BUS_WB.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  bus accepts the beat.
- rsp_data  out  BEAT_BITS  response data beat.
- rsp_last  out  1  final beat of the response.
- rsp_shared  out  1  this cache supplies the line; high with every beat.
- cache_addr  out  ADDR_BITS-OFFSET_BITS  lookup address to the cache.
- cacheline_lookup  in  l1_cacheline_t  combinational lookup result from the cache.
- cacheline_update  out  l1_cacheline_t  line write-back value to the cache.
- update_valid  out  1  one-cycle strobe that writes cacheline_update.

Function
REQ-005 SHALL queue requests in a FIFO_DEPTH-entry FIFO; push on snp_valid && snp_ready.
REQ-006 SHALL drive snp_ready = !full; when full, a same-cycle pop SHALL NOT raise snp_ready (no bypass).
REQ-007 SHALL use a 2-state FSM, LOOKUP and RESPOND.
REQ-008 SHALL drive cache_addr = FIFO head address at all times; the address is don't-care when the FIFO is empty.
REQ-009 In LOOKUP with the FIFO non-empty, SHALL evaluate the head request in one cycle and pop it in that same cycle.
REQ-010 A hit SHALL require tag == head_addr[upper bits above L1_INDEX_BITS] and state != I; a miss SHALL pop the request with no update and no response.
REQ-011 On a hit, SHALL apply these actions:
- BUS_WB: no action.
- BUS_UPGR: update the line to I.
- BUS_RD: supply the line; E->S; M->O.
- BUS_RDX: update the line to I; supply the line unless its state was S.
- Other request values: no action.
REQ-012 update_valid SHALL pulse for exactly the evaluation cycle; cacheline_update = cacheline_lookup with only the state field modified.
REQ-013 On a supply, SHALL capture cacheline_lookup.cacheline into a line buffer, go to RESPOND, and clear the beat counter.
REQ-014 In RESPOND:
- rsp_valid = 1 and rsp_shared = 1.
- rsp_data = line buffer bits [beat*BEAT_BITS +: BEAT_BITS]; beat 0 is the least-significant beat.
- rsp_last = (beat == NBEATS-1).
REQ-015 The beat counter SHALL advance only on rsp_valid && rsp_ready; rsp_data SHALL hold stable while rsp_ready is low.
REQ-016 The final accepted beat SHALL return the FSM to LOOKUP; the next queued request SHALL be evaluated no earlier than the following cycle.
REQ-017 The FIFO SHALL NOT pop in RESPOND; snp_valid SHALL still be accepted while not full.
REQ-018 Outside RESPOND, rsp_valid, rsp_shared, rsp_last and rsp_data SHALL all be 0.
REQ-019 The latency from push into an empty FIFO to the first beat SHALL be 2 cycles: one to enqueue, one to evaluate.

Reset
REQ-020 On reset assertion, the engine SHALL asynchronously clear:
- FSM to LOOKUP.
- FIFO pointers and count to empty.
- Beat counter and line buffer to 0.
REQ-021 Reset mid-response SHALL abort the response immediately; queued requests are discarded.
REQ-022 During reset: snp_ready = 0, rsp_valid = 0, update_valid = 0. snp_ready SHALL rise in the first cycle after deassertion.

Configuration
REQ-023 Macro SNOOP_OWNED_EN SHALL select the coherence protocol:
- Defined: MOESI; BUS_RD on M -> O.
- Undefined: MESI; BUS_RD on M -> S, and O is never produced (the other REQ-011 rules are unchanged).

Structure
REQ-024 bus_req_t, l1_cacheline_t, the coherence state enum and the address-width macros SHALL come from the shared cache.svh/package; the FSM state enum SHALL be local.
REQ-025 The queue SHALL be a sub-module snoop_fifo (parameters WIDTH and DEPTH; push, pop, head, full, empty).

Verification
REQ-026 The bench SHALL cover these directed scenarios (LINE_BITS=512, BEAT_BITS=128, FIFO_DEPTH=4):
- BUS_RD hit on E line 0xAA..AA: update_valid one cycle with state S; 4 beats, rsp_last on beat 3, rsp_shared high throughout.
- BUS_RDX hit on S: update to I, no rsp_valid; BUS_RDX hit on M: update to I plus 4 beats.
- Five back-to-back pushes while rsp_ready = 0: snp_ready low after 4; the fifth is accepted only after the FIFO pops.
- BUS_RD hit on M: state O with SNOOP_OWNED_EN, state S without it.
- rsp_ready toggling 1,0,0,1 mid-response: beats stay in order and data holds while stalled.
- reset_n asserted during beat 2: rsp_valid = 0 immediately; FIFO empty; snp_ready = 1 after release.
